chroni_fetch: RTL

Memory-fetch initiator inside chroni: on a start pulse it reads a run of consecutive bytes from system memory over the rd_req/rd_ack bus handshake and buffers them in a small FIFO for the pixel pipeline. It is the requesting end of the interface serviced by the system bus state machine, which returns ROM or RAM data on data_in. One request is outstanding at a time. Fetching throttles automatically when the FIFO fills.

---
 rtl/chroni_fetch_pkg.sv | 23 ++
 rtl/chroni_fetch_fifo.sv | 74 +++++++
 rtl/chroni_fetch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/chroni_fetch_pkg.sv
// ============================================================================
// Module  : chroni_fetch_pkg
// Brief   : Shared constants and FSM encoding for the chroni memory fetcher.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package chroni_fetch_pkg;

    localparam int C_ADDR_W_DEFAULT     = 14;
    localparam int C_FIFO_DEPTH_DEFAULT = 16;
    localparam int C_BYTE_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_FULL_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/chroni_fetch_fifo.sv
// ============================================================================
// Module  : chroni_fetch_fifo
// Brief   : Show-ahead byte FIFO with push, pop, flush, level, empty and full.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module chroni_fetch_fifo
    import chroni_fetch_pkg::*;
#(
    parameter int DEPTH = C_FIFO_DEPTH_DEFAULT
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [C_BYTE_W-1:0]     i_wdata,
    input  logic                    i_pop,
    input  logic                    i_flush,
    output logic [C_BYTE_W-1:0]     o_rdata,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [C_BYTE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/chroni_fetch.sv
// ============================================================================
// Module  : chroni_fetch
// Brief   : Bus read initiator that fetches a byte run into a small FIFO.
//           Optional ack watchdog enabled by defining CHRONI_FETCH_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module chroni_fetch
    import chroni_fetch_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W_DEFAULT,
    parameter int FIFO_DEPTH = C_FIFO_DEPTH_DEFAULT
`ifdef CHRONI_FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
)(
    input  logic                          sys_clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [7:0]                    count,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W-1:0]             addr_out,
    output logic                          rd_req,
    input  logic                          rd_ack,
    input  logic [7:0]                    data_in,
    input  logic                          pop,
    output logic [7:0]                    fifo_data,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fetch_err
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nx;
    logic              r_rd_req;
    logic              w_rd_req_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [7:0]        r_rem;
    logic [7:0]        w_rem_nx;
    logic              r_busy;
    logic              w_busy_nx;
    logic              r_done;
    logic              w_timeout;
    logic              w_abort;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_full_after;
    logic              w_start_ok;

    assign w_abort    = abort || w_timeout;
    assign w_push     = (r_state == ST_REQ) && r_rd_req && rd_ack && !w_abort;
    assign w_pop      = pop && !fifo_empty;
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    // A push with no pop fills the last free slot only from DEPTH-1.
    assign w_full_after = !w_pop &&
                          (fifo_level == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH - 1));

    always_comb begin
        w_state_nx  = r_state;
        w_rd_req_nx = r_rd_req;
        w_addr_nx   = r_addr;
        w_rem_nx    = r_rem;
        w_busy_nx   = r_busy;
        if (w_abort) begin
            w_state_nx  = ST_IDLE;
            w_rd_req_nx = 1'b0;
            w_rem_nx    = '0;
            w_busy_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_busy_nx = 1'b1;
                        if (count == 8'd0) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_state_nx  = ST_REQ;
                            w_rd_req_nx = 1'b1;
                            w_addr_nx   = base_addr;
                            w_rem_nx    = count;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_push) begin
                        w_addr_nx = r_addr + ADDR_W'(1);
                        w_rem_nx  = r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            w_state_nx  = ST_DONE;
                            w_rd_req_nx = 1'b0;
                        end else if (w_full_after) begin
                            w_state_nx  = ST_FULL_WAIT;
                            w_rd_req_nx = 1'b0;
                        end
                    end
                end
                ST_FULL_WAIT: begin
                    if (!w_full) begin
                        w_state_nx  = ST_REQ;
                        w_rd_req_nx = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nx = ST_IDLE;
                    w_busy_nx  = 1'b0;
                end
                default: begin
                    w_state_nx  = ST_IDLE;
                    w_rd_req_nx = 1'b0;
                    w_busy_nx   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_rd_req <= 1'b0;
            r_addr   <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rd_req <= w_rd_req_nx;
            r_addr   <= w_addr_nx;
            r_rem    <= w_rem_nx;
            r_busy   <= w_busy_nx;
            r_done   <= (w_state_nx == ST_DONE);
        end
    end

`ifdef CHRONI_FETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    assign w_timeout = (r_state == ST_REQ) &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign fetch_err = r_err;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state != ST_REQ) || (r_rd_req && rd_ack) || abort) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_start_ok) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    chroni_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_wdata (data_in),
        .i_pop   (pop),
        .i_flush (w_abort),
        .o_rdata (fifo_data),
        .o_empty (fifo_empty),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_req   = r_rd_req;
    assign addr_out = r_addr;

endmodule

`default_nettype wire
